gate_unit_arbiter: RTL

- Shares one WIDTH-bit bitwise gate unit between N_REQ requesters.
- Round-robin arbitration; each requester uses a valid/ready handshake.
- The result is registered in a single-entry output slot, tagged with the requester index, and drained through a valid/ready response port.
- Sits between gate-level clients and the shared logic datapath.

---
 rtl/gate_unit_pkg.sv | 16 +
 rtl/gate_unit_arbiter_if.sv | 27 ++
 rtl/gate_op_unit.sv | 39 +++
 rtl/gate_unit_primitives.sv | 15 +
 rtl/gate_unit_arbiter.sv | 116 +++++++++++
 5 files changed

// File: rtl/gate_unit_pkg.sv
// Shared encodings for the gate-unit arbiter: operation codes and slot FSM states.
package gate_unit_pkg;

  typedef enum logic [1:0] {
    OP_AND  = 2'b00,
    OP_NOT  = 2'b01,
    OP_NAND = 2'b10,
    OP_OR   = 2'b11
  } op_t;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

endpackage

// File: rtl/gate_unit_arbiter_if.sv
// Requester and response bundle of the gate-unit arbiter; slave is the arbiter side.
interface gate_unit_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8
);
  localparam int ID_W = $clog2(N_REQ);

  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ-1:0]       req_ready;
  logic [2*N_REQ-1:0]     req_op;
  logic [N_REQ*WIDTH-1:0] req_a;
  logic [N_REQ*WIDTH-1:0] req_b;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [WIDTH-1:0]       rsp_data;
  logic [ID_W-1:0]        rsp_id;

  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_id
  );

  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_id
  );
endinterface

// File: rtl/gate_op_unit.sv
// Combinational WIDTH-bit gate unit built per bit from not/and primitives.
module gate_op_unit
  import gate_unit_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);
  logic [WIDTH-1:0] w_not_a;
  logic [WIDTH-1:0] w_not_b;
  logic [WIDTH-1:0] w_and;
  logic [WIDTH-1:0] w_nand;
  logic [WIDTH-1:0] w_nor;
  logic [WIDTH-1:0] w_or;

  // OR is formed as NOT(NOT a AND NOT b) so only not/and cells are used.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    not_gate u_not_a (.i_a(a[i]),       .o_y(w_not_a[i]));
    not_gate u_not_b (.i_a(b[i]),       .o_y(w_not_b[i]));
    and_gate u_and   (.i_a(a[i]),       .i_b(b[i]),       .o_y(w_and[i]));
    not_gate u_nand  (.i_a(w_and[i]),   .o_y(w_nand[i]));
    and_gate u_nor   (.i_a(w_not_a[i]), .i_b(w_not_b[i]), .o_y(w_nor[i]));
    not_gate u_or    (.i_a(w_nor[i]),   .o_y(w_or[i]));
  end

  always_comb begin
    y = w_and;
    case (op_t'(op))
      OP_AND:  y = w_and;
      OP_NOT:  y = w_not_a;
      OP_NAND: y = w_nand;
      OP_OR:   y = w_or;
      default: y = w_and;
    endcase
  end
endmodule

// File: rtl/gate_unit_primitives.sv
// Single-bit gate primitives the shared gate unit is assembled from.
module not_gate (
  input  logic i_a,
  output logic o_y
);
  assign o_y = ~i_a;
endmodule

module and_gate (
  input  logic i_a,
  input  logic i_b,
  output logic o_y
);
  assign o_y = i_a & i_b;
endmodule

// File: rtl/gate_unit_arbiter.sv
// Round-robin arbiter sharing one gate unit among N_REQ requesters, with a
// single-entry tagged result slot drained through a valid/ready port.
module gate_unit_arbiter
  import gate_unit_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8
) (
  input logic                clk,
  input logic                rst_n,
  gate_unit_arbiter_if.slave bus
);
  localparam int ID_W = $clog2(N_REQ);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [ID_W-1:0]  r_ptr;
  logic [ID_W-1:0]  r_rsp_id;
  logic [WIDTH-1:0] r_rsp_data;

  logic             w_slot_avail;
  logic             w_grant_any;
  logic [N_REQ-1:0] w_grant_vec;
  logic [ID_W-1:0]  w_grant_id;
  logic [ID_W-1:0]  w_ptr_nxt;
  logic [1:0]       w_op_g;
  logic [WIDTH-1:0] w_a_g;
  logic [WIDTH-1:0] w_b_g;
  logic [WIDTH-1:0] w_gate_y;

  assign w_slot_avail = (r_state == ST_EMPTY) | ((r_state == ST_FULL) & bus.rsp_ready);

  // Two ordered passes give the circular search ptr..N_REQ-1 then 0..ptr-1.
  always_comb begin
    w_grant_any = 1'b0;
    w_grant_vec = '0;
    w_grant_id  = '0;
    if (w_slot_avail) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (!w_grant_any && (i >= int'(r_ptr)) && bus.req_valid[i]) begin
          w_grant_any    = 1'b1;
          w_grant_vec[i] = 1'b1;
          w_grant_id     = ID_W'(i);
        end
      end
      for (int i = 0; i < N_REQ; i++) begin
        if (!w_grant_any && (i < int'(r_ptr)) && bus.req_valid[i]) begin
          w_grant_any    = 1'b1;
          w_grant_vec[i] = 1'b1;
          w_grant_id     = ID_W'(i);
        end
      end
    end
  end

  // Reset drops slot state to EMPTY, so grants must be masked explicitly.
  assign bus.req_ready = rst_n ? w_grant_vec : '0;

  always_comb begin
    w_op_g = '0;
    w_a_g  = '0;
    w_b_g  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_grant_id == ID_W'(i)) begin
        w_op_g = bus.req_op[2*i +: 2];
        w_a_g  = bus.req_a[i*WIDTH +: WIDTH];
        w_b_g  = bus.req_b[i*WIDTH +: WIDTH];
      end
    end
  end

  assign w_ptr_nxt = (w_grant_id == ID_W'(N_REQ - 1)) ? '0 : w_grant_id + 1'b1;

  gate_op_unit #(.WIDTH(WIDTH)) u_gate (
    .op (w_op_g),
    .a  (w_a_g),
    .b  (w_b_g),
    .y  (w_gate_y)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_EMPTY;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_EMPTY: if (w_grant_any) w_state_nxt = ST_FULL;
      ST_FULL: begin
        if (w_grant_any)        w_state_nxt = ST_FULL;
        else if (bus.rsp_ready) w_state_nxt = ST_EMPTY;
      end
      default: w_state_nxt = ST_EMPTY;
    endcase
  end

  always_comb begin
    bus.rsp_valid = (r_state == ST_FULL);
    bus.rsp_data  = r_rsp_data;
    bus.rsp_id    = r_rsp_id;
  end

  // A draining slot keeps its last data/id; only an accept overwrites them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_data <= '0;
      r_rsp_id   <= '0;
      r_ptr      <= '0;
    end else if (w_grant_any) begin
      r_rsp_data <= w_gate_y;
      r_rsp_id   <= w_grant_id;
      r_ptr      <= w_ptr_nxt;
    end
  end
endmodule
